// File: rtl/rdma_pkg.sv
// Shared AXI constants and AR front-end state encoding for the read-DMA path.
package rdma_pkg;

    localparam logic [1:0]  AXI_BURST_INCR = 2'b01;
    localparam int unsigned AXI_4K_BYTES   = 4096;

    typedef enum logic [1:0] {
        StIdle,
        StCalc,
        StWait,
        StIssue
    } ar_state_e;

endpackage

// File: rtl/rdma_burst_len_calc.sv
// Combinational burst sizing: min(remaining, 2^LEN_W) and, with RDMA_AR_4K_SPLIT_EN defined,
// also the number of beats left before the next 4 KB boundary.
module rdma_burst_len_calc
    import rdma_pkg::*;
#(
    parameter int unsigned ADDR_W     = 32,
    parameter int unsigned LEN_W      = 4,
    parameter int unsigned CNT_W      = 16,
    parameter int unsigned BEAT_BYTES = 8
) (
    input  logic [ADDR_W-1:0] addr,
    input  logic [CNT_W-1:0]  remaining,
    output logic [LEN_W:0]    burst_beats
);

    localparam int unsigned BS = $clog2(BEAT_BYTES);
    // Wide enough for remaining, 2^LEN_W and a full 4 KB page worth of beats.
    localparam int unsigned CW = ((CNT_W > 13) ? CNT_W : 13) + 1;

    logic [CW-1:0] rem_ext;
    logic [CW-1:0] cap_max;
    logic [CW-1:0] min_beats;
    logic          unused_addr;

    assign unused_addr = ^addr;

`ifdef RDMA_AR_4K_SPLIT_EN
    logic [12:0]   bytes_to_4k;
    logic [CW-1:0] beats_to_4k;

    assign bytes_to_4k = 13'(AXI_4K_BYTES) - {1'b0, addr[11:0]};
    assign beats_to_4k = CW'(bytes_to_4k >> BS);
`endif

    always_comb begin
        rem_ext   = CW'(remaining);
        cap_max   = CW'(1) << LEN_W;
        min_beats = (rem_ext < cap_max) ? rem_ext : cap_max;
`ifdef RDMA_AR_4K_SPLIT_EN
        if (beats_to_4k < min_beats) begin
            min_beats = beats_to_4k;
        end
`endif
        burst_beats = min_beats[LEN_W:0];
    end

endmodule

// File: rtl/rdma_ar_burst_gen.sv
// Read-DMA AR front end: splits a (start address, beat count) command into AXI INCR bursts and
// pushes each accepted arlen into the R-side length FIFO. 4 KB splitting: RDMA_AR_4K_SPLIT_EN.
module rdma_ar_burst_gen
    import rdma_pkg::*;
#(
    parameter int unsigned ADDR_W     = 32,
    parameter int unsigned LEN_W      = 4,
    parameter int unsigned CNT_W      = 16,
    parameter int unsigned BEAT_BYTES = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              cmd_valid,
    output logic              cmd_ready,
    input  logic [ADDR_W-1:0] cmd_addr,
    input  logic [CNT_W-1:0]  cmd_beats,
    output logic [ADDR_W-1:0] m_axi_araddr,
    output logic [LEN_W-1:0]  m_axi_arlen,
    output logic [2:0]        m_axi_arsize,
    output logic [1:0]        m_axi_arburst,
    output logic              m_axi_arvalid,
    input  logic              m_axi_arready,
    output logic [LEN_W-1:0]  lenfifo_arlen,
    output logic              lenfifo_push,
    input  logic              lenfifo_full_n,
    output logic              busy,
    output logic              done
);

    localparam int unsigned       BS        = $clog2(BEAT_BYTES);
    localparam int unsigned       BW        = LEN_W + 1;
    localparam logic [ADDR_W-1:0] ADDR_MASK = ~ADDR_W'(BEAT_BYTES - 1);

    ar_state_e         state_q, state_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [CNT_W-1:0]  remaining_q, remaining_d;
    logic [LEN_W-1:0]  arlen_q, arlen_d;
    logic              arvalid_q, arvalid_d;
    logic [BW-1:0]     burst_beats;
    logic [BW-1:0]     cur_beats;

    rdma_burst_len_calc #(
        .ADDR_W     (ADDR_W),
        .LEN_W      (LEN_W),
        .CNT_W      (CNT_W),
        .BEAT_BYTES (BEAT_BYTES)
    ) u_len_calc (
        .addr        (addr_q),
        .remaining   (remaining_q),
        .burst_beats (burst_beats)
    );

    // The issued burst length is recovered from arlen so only one length register is kept.
    assign cur_beats = {1'b0, arlen_q} + BW'(1);

    always_comb begin
        state_d     = state_q;
        addr_d      = addr_q;
        remaining_d = remaining_q;
        arlen_d     = arlen_q;
        arvalid_d   = arvalid_q;
        unique case (state_q)
            StIdle: begin
                if (cmd_valid) begin
                    addr_d      = cmd_addr & ADDR_MASK;
                    remaining_d = cmd_beats;
                    state_d     = StCalc;
                end
            end
            StCalc: begin
                if (remaining_q == '0) begin
                    state_d = StIdle;
                end else begin
                    arlen_d = LEN_W'(burst_beats - BW'(1));
                    state_d = StWait;
                end
            end
            StWait: begin
                if (lenfifo_full_n) begin
                    arvalid_d = 1'b1;
                    state_d   = StIssue;
                end
            end
            StIssue: begin
                if (m_axi_arready) begin
                    arvalid_d   = 1'b0;
                    addr_d      = addr_q + (ADDR_W'(cur_beats) << BS);
                    remaining_d = remaining_q - CNT_W'(cur_beats);
                    state_d     = StCalc;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= StIdle;
            addr_q      <= '0;
            remaining_q <= '0;
            arlen_q     <= '0;
            arvalid_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            addr_q      <= addr_d;
            remaining_q <= remaining_d;
            arlen_q     <= arlen_d;
            arvalid_q   <= arvalid_d;
        end
    end

    assign cmd_ready     = (state_q == StIdle) && !rst;
    assign busy          = (state_q != StIdle);
    assign done          = (state_q == StCalc) && (remaining_q == '0) && !rst;
    assign m_axi_araddr  = addr_q;
    assign m_axi_arlen   = arlen_q;
    assign m_axi_arsize  = 3'(BS);
    assign m_axi_arburst = AXI_BURST_INCR;
    assign m_axi_arvalid = arvalid_q;
    assign lenfifo_arlen = arlen_q;
    assign lenfifo_push  = arvalid_q && m_axi_arready;

endmodule

// File: tb/tb_rdma_ar_burst_gen.sv
// Self-checking bench for rdma_ar_burst_gen: expected AR bursts are queued per command and
// popped by a monitor on every AR handshake.
module tb_rdma_ar_burst_gen;

    typedef struct packed {
        logic [31:0] addr;
        logic [3:0]  len;
    } burst_t;

    logic        clk;
    logic        rst;
    logic        cmd_valid;
    logic        cmd_ready;
    logic [31:0] cmd_addr;
    logic [15:0] cmd_beats;
    logic [31:0] m_axi_araddr;
    logic [3:0]  m_axi_arlen;
    logic [2:0]  m_axi_arsize;
    logic [1:0]  m_axi_arburst;
    logic        m_axi_arvalid;
    logic        m_axi_arready;
    logic [3:0]  lenfifo_arlen;
    logic        lenfifo_push;
    logic        lenfifo_full_n;
    logic        busy;
    logic        done;

    int     n_tests = 0;
    int     n_fail  = 0;
    int     push_cnt = 0;
    int     done_cnt = 0;
    burst_t exp_q[$];

    rdma_ar_burst_gen #(
        .ADDR_W     (32),
        .LEN_W      (4),
        .CNT_W      (16),
        .BEAT_BYTES (8)
    ) dut (
        .clk            (clk),
        .rst            (rst),
        .cmd_valid      (cmd_valid),
        .cmd_ready      (cmd_ready),
        .cmd_addr       (cmd_addr),
        .cmd_beats      (cmd_beats),
        .m_axi_araddr   (m_axi_araddr),
        .m_axi_arlen    (m_axi_arlen),
        .m_axi_arsize   (m_axi_arsize),
        .m_axi_arburst  (m_axi_arburst),
        .m_axi_arvalid  (m_axi_arvalid),
        .m_axi_arready  (m_axi_arready),
        .lenfifo_arlen  (lenfifo_arlen),
        .lenfifo_push   (lenfifo_push),
        .lenfifo_full_n (lenfifo_full_n),
        .busy           (busy),
        .done           (done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Scoreboard monitor: every AR handshake must match the head of the expected queue.
    always @(negedge clk) begin
        if (!rst) begin
            if (lenfifo_push) push_cnt++;
            if (done) done_cnt++;
            if (m_axi_arvalid && m_axi_arready) begin
                burst_t e;
                n_tests++;
                if (exp_q.size() == 0) begin
                    n_fail++;
                    $display("FAIL unexpected_burst: got addr=%h len=%0d, expected no burst",
                             m_axi_araddr, m_axi_arlen);
                end else begin
                    e = exp_q.pop_front();
                    if (m_axi_araddr !== e.addr) begin
                        n_fail++;
                        $display("FAIL burst_addr: got %h, expected %h", m_axi_araddr, e.addr);
                    end
                    n_tests++;
                    if (m_axi_arlen !== e.len) begin
                        n_fail++;
                        $display("FAIL burst_len: got %0d, expected %0d", m_axi_arlen, e.len);
                    end
                    n_tests++;
                    if (lenfifo_arlen !== e.len) begin
                        n_fail++;
                        $display("FAIL fifo_len: got %0d, expected %0d", lenfifo_arlen, e.len);
                    end
                end
                n_tests++;
                if (lenfifo_push !== 1'b1) begin
                    n_fail++;
                    $display("FAIL push_on_handshake: got %b, expected 1", lenfifo_push);
                end
            end else if (lenfifo_push !== 1'b0) begin
                n_tests++;
                n_fail++;
                $display("FAIL push_without_handshake: got %b, expected 0", lenfifo_push);
            end
        end
    end

    task automatic send_cmd(input logic [31:0] a, input logic [15:0] b);
        int t = 0;
        @(negedge clk);
        while (!cmd_ready && t < 100) begin
            @(negedge clk);
            t++;
        end
        n_tests++;
        if (cmd_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL cmd_ready_timeout: got %b, expected 1", cmd_ready);
        end
        cmd_addr  = a;
        cmd_beats = b;
        cmd_valid = 1'b1;
        @(posedge clk);
        #1 cmd_valid = 1'b0;
    endtask

    // Waits for done, then checks the block is idle one cycle later and the queue drained.
    task automatic wait_done(input string name);
        int t = 0;
        @(negedge clk);
        while (!done && t < 300) begin
            @(negedge clk);
            t++;
        end
        n_tests++;
        if (done !== 1'b1) begin
            n_fail++;
            $display("FAIL %s_done_timeout: got %b, expected 1", name, done);
        end
        @(negedge clk);
        n_tests++;
        if (busy !== 1'b0 || done !== 1'b0) begin
            n_fail++;
            $display("FAIL %s_idle_after_done: got busy=%b done=%b, expected 0 0", name, busy,
                     done);
        end
        n_tests++;
        if (exp_q.size() != 0) begin
            n_fail++;
            $display("FAIL %s_bursts_missing: got %0d left, expected 0", name, exp_q.size());
        end
    endtask

    task automatic wait_arvalid(input string name);
        int t = 0;
        @(negedge clk);
        while (!m_axi_arvalid && t < 100) begin
            @(negedge clk);
            t++;
        end
        n_tests++;
        if (m_axi_arvalid !== 1'b1) begin
            n_fail++;
            $display("FAIL %s_arvalid_timeout: got %b, expected 1", name, m_axi_arvalid);
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (3) @(negedge clk);
        n_tests++;
        if ({m_axi_arvalid, m_axi_araddr, m_axi_arlen, lenfifo_push, busy, done, cmd_ready}
            !== '0) begin
            n_fail++;
            $display("FAIL reset_outputs: got arvalid=%b addr=%h len=%0d push=%b busy=%b done=%b ready=%b, expected all 0",
                     m_axi_arvalid, m_axi_araddr, m_axi_arlen, lenfifo_push, busy, done,
                     cmd_ready);
        end
        n_tests++;
        if (m_axi_arsize !== 3'd3 || m_axi_arburst !== 2'b01) begin
            n_fail++;
            $display("FAIL reset_consts: got size=%0d burst=%b, expected 3 01", m_axi_arsize,
                     m_axi_arburst);
        end
        rst = 1'b0;
        @(negedge clk);
        n_tests++;
        if (cmd_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL ready_after_reset: got %b, expected 1", cmd_ready);
        end
    endtask

    task automatic test_split_basic();
        int d0 = done_cnt;
        exp_q.push_back('{addr: 32'h1000, len: 4'd15});
        exp_q.push_back('{addr: 32'h1080, len: 4'd15});
        exp_q.push_back('{addr: 32'h1100, len: 4'd7});
        send_cmd(32'h1000, 16'd40);
        wait_done("basic");
        n_tests++;
        if (done_cnt != d0 + 1) begin
            n_fail++;
            $display("FAIL basic_done_count: got %0d, expected 1", done_cnt - d0);
        end
    endtask

    task automatic test_4k_boundary();
`ifdef RDMA_AR_4K_SPLIT_EN
        exp_q.push_back('{addr: 32'h0FC0, len: 4'd7});
        exp_q.push_back('{addr: 32'h1000, len: 4'd11});
`else
        exp_q.push_back('{addr: 32'h0FC0, len: 4'd15});
        exp_q.push_back('{addr: 32'h1040, len: 4'd3});
`endif
        send_cmd(32'h0FC0, 16'd20);
        wait_done("boundary4k");
    endtask

    task automatic test_fifo_full();
        int p0 = push_cnt;
        lenfifo_full_n = 1'b0;
        // Unaligned low bits must be dropped.
        exp_q.push_back('{addr: 32'h3000, len: 4'd7});
        send_cmd(32'h3005, 16'd8);
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            n_tests++;
            if (m_axi_arvalid !== 1'b0 || push_cnt != p0) begin
                n_fail++;
                $display("FAIL full_hold_c%0d: got arvalid=%b pushes=%0d, expected 0 0", i,
                         m_axi_arvalid, push_cnt - p0);
            end
        end
        lenfifo_full_n = 1'b1;
        @(negedge clk);
        n_tests++;
        if (m_axi_arvalid !== 1'b1) begin
            n_fail++;
            $display("FAIL full_release: got arvalid=%b, expected 1", m_axi_arvalid);
        end
        wait_done("fifo_full");
    endtask

    task automatic test_arready_stall();
        int p0 = push_cnt;
        m_axi_arready = 1'b0;
        exp_q.push_back('{addr: 32'h4000, len: 4'd3});
        send_cmd(32'h4000, 16'd4);
        wait_arvalid("stall");
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            n_tests++;
            if (m_axi_arvalid !== 1'b1 || m_axi_araddr !== 32'h4000 || m_axi_arlen !== 4'd3
                || push_cnt != p0) begin
                n_fail++;
                $display("FAIL stall_stable_c%0d: got v=%b a=%h l=%0d pushes=%0d, expected 1 4000 3 0",
                         i, m_axi_arvalid, m_axi_araddr, m_axi_arlen, push_cnt - p0);
            end
        end
        m_axi_arready = 1'b1;
        wait_done("stall");
        n_tests++;
        if (push_cnt != p0 + 1) begin
            n_fail++;
            $display("FAIL stall_push_count: got %0d, expected 1", push_cnt - p0);
        end
    endtask

    task automatic test_zero_beats();
        int p0 = push_cnt;
        send_cmd(32'h6000, 16'd0);
        @(negedge clk);
        n_tests++;
        if (done !== 1'b1 || busy !== 1'b1 || m_axi_arvalid !== 1'b0) begin
            n_fail++;
            $display("FAIL zero_calc_cycle: got done=%b busy=%b arvalid=%b, expected 1 1 0",
                     done, busy, m_axi_arvalid);
        end
        @(negedge clk);
        n_tests++;
        if (done !== 1'b0 || busy !== 1'b0 || push_cnt != p0) begin
            n_fail++;
            $display("FAIL zero_after: got done=%b busy=%b pushes=%0d, expected 0 0 0", done,
                     busy, push_cnt - p0);
        end
    endtask

    task automatic test_reset_abort();
        int d0 = done_cnt;
        int p0;
        m_axi_arready = 1'b0;
        send_cmd(32'h5000, 16'd40);
        wait_arvalid("abort");
        rst = 1'b1;
        @(posedge clk);
        #1;
        n_tests++;
        if (m_axi_arvalid !== 1'b0 || busy !== 1'b0 || done !== 1'b0) begin
            n_fail++;
            $display("FAIL abort_state: got arvalid=%b busy=%b done=%b, expected 0 0 0",
                     m_axi_arvalid, busy, done);
        end
        @(negedge clk);
        rst = 1'b0;
        m_axi_arready = 1'b1;
        repeat (3) @(negedge clk);
        n_tests++;
        if (done_cnt != d0 || m_axi_arvalid !== 1'b0) begin
            n_fail++;
            $display("FAIL abort_no_done: got dones=%0d arvalid=%b, expected 0 0",
                     done_cnt - d0, m_axi_arvalid);
        end
        p0 = push_cnt;
        exp_q.push_back('{addr: 32'h2000, len: 4'd15});
        send_cmd(32'h2000, 16'd16);
        wait_done("after_abort");
        n_tests++;
        if (push_cnt != p0 + 1) begin
            n_fail++;
            $display("FAIL after_abort_push_count: got %0d, expected 1", push_cnt - p0);
        end
    endtask

    initial begin
        rst            = 1'b1;
        cmd_valid      = 1'b0;
        cmd_addr       = '0;
        cmd_beats      = '0;
        m_axi_arready  = 1'b1;
        lenfifo_full_n = 1'b1;
        test_reset();
        test_split_basic();
        test_4k_boundary();
        test_fifo_full();
        test_arready_stall();
        test_zero_beats();
        test_reset_abort();
        repeat (2) @(negedge clk);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
